// File: rtl/gost_mode_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gost_mode_chain: ECB/CBC/CFB/OFB/CTR mode engine around an external core |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gost_mode_chain #(
  parameter int BLOCK_W = 128,
  parameter int CTR_W   = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         mode,
  input  logic               encrypt,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               init,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               core_start,
  output logic               core_dec,
  output logic [BLOCK_W-1:0] core_din,
  input  logic [BLOCK_W-1:0] core_dout,
  input  logic               core_done
);

  localparam logic [2:0] M_ECB = 3'd0;
  localparam logic [2:0] M_CBC = 3'd1;
  localparam logic [2:0] M_CFB = 3'd2;
  localparam logic [2:0] M_OFB = 3'd3;
  localparam logic [2:0] M_CTR = 3'd4;
  localparam logic [BLOCK_W-1:0] CTR_MASK = {BLOCK_W{1'b1}} >> (BLOCK_W - CTR_W);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t             state, state_nxt;
  logic [BLOCK_W-1:0] chain, x_reg;
  logic [2:0]         mode_reg;
  logic               enc_reg;
  logic               accept, done_hit;
  logic [BLOCK_W-1:0] din_nxt, out_nxt, chain_nxt, ctr_inc;
  logic               dec_nxt;

  always_comb begin
    in_ready   = (state == IDLE) && !init && (mode <= M_CTR);
    accept     = in_valid && in_ready;
    done_hit   = (state == WAIT) && core_done;
    core_start = (state == START);
    out_valid  = (state == OUT);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (core_done) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Core input is fixed at acceptance from the live mode/direction and chain.
  always_comb begin
    din_nxt = in_data;
    dec_nxt = 1'b0;
    case (mode)
      M_ECB: dec_nxt = ~encrypt;
      M_CBC: begin
        dec_nxt = ~encrypt;
        if (encrypt) din_nxt = in_data ^ chain;
      end
      M_CFB, M_OFB, M_CTR: din_nxt = chain;
      default: din_nxt = in_data;
    endcase
  end

  // Counter carry is masked so a wrap of the low field never reaches the nonce.
  assign ctr_inc = (chain & ~CTR_MASK) | ((chain + BLOCK_W'(1)) & CTR_MASK);

  always_comb begin
    out_nxt   = core_dout;
    chain_nxt = chain;
    case (mode_reg)
      M_CBC: begin
        if (enc_reg) begin
          chain_nxt = core_dout;
        end else begin
          out_nxt   = core_dout ^ chain;
          chain_nxt = x_reg;
        end
      end
      M_CFB: begin
        out_nxt   = x_reg ^ core_dout;
        chain_nxt = enc_reg ? (x_reg ^ core_dout) : x_reg;
      end
      M_OFB: begin
        out_nxt   = x_reg ^ core_dout;
        chain_nxt = core_dout;
      end
      M_CTR: begin
        out_nxt   = x_reg ^ core_dout;
        chain_nxt = ctr_inc;
      end
      default: out_nxt = core_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      chain    <= '0;
      x_reg    <= '0;
      mode_reg <= '0;
      enc_reg  <= 1'b0;
      out_data <= '0;
      core_din <= '0;
      core_dec <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && init) chain <= iv;
      if (accept) begin
        x_reg    <= in_data;
        mode_reg <= mode;
        enc_reg  <= encrypt;
        core_din <= din_nxt;
        core_dec <= dec_nxt;
      end
      if (done_hit) begin
        out_data <= out_nxt;
        chain    <= chain_nxt;
      end
    end
  end

endmodule
`default_nettype wire
